// File: rtl/alu_4bit_issuer.sv
// Initiator for the registered 4-bit ALU: issues commands and tracks each one through the ALU
// latency. Every result is checked against a locally computed expected value and queued.
module alu_4bit_issuer #(
    parameter int unsigned ALU_LAT   = 2,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_sel,
    input  logic [3:0]       alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_mismatch
);

    localparam int unsigned NumStages = ALU_LAT + 1;
    localparam int unsigned Last      = NumStages - 1;
    localparam int unsigned CntW      = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PtrW      = $clog2(RSP_DEPTH);

    logic accept;
    logic pop;
    logic capture;

    // Credits: one per FIFO slot, so a capture can never find the FIFO full.
    logic [CntW-1:0] credit_q, credit_d;

    assign cmd_ready = (credit_q != '0) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        credit_d = credit_q;
        unique case ({accept, pop})
            2'b10:   credit_d = credit_q - CntW'(1);
            2'b01:   credit_d = credit_q + CntW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= CntW'(RSP_DEPTH);
        end else begin
            credit_q <= credit_d;
        end
    end

    logic [3:0] exp_result;
    logic       exp_zero;

    always_comb begin
        exp_result = '0;
        unique case (cmd_op)
            2'b00:   exp_result = cmd_a + cmd_b;
            2'b01:   exp_result = cmd_a + ~cmd_b + 4'd1;
            2'b10:   exp_result = cmd_a & cmd_b;
            2'b11:   exp_result = cmd_a | cmd_b;
            default: exp_result = '0;
        endcase
        exp_zero = (exp_result == 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (accept) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_op;
        end
    end

    // Shadow pipeline that moves in lockstep with the ALU's internal registers.
    logic [NumStages-1:0] pipe_valid_q;
    logic [NumStages-1:0] pipe_zero_q;
    logic [TAG_W-1:0]     pipe_tag_q [NumStages];
    logic [3:0]           pipe_res_q [NumStages];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid_q <= '0;
            pipe_zero_q  <= '0;
            for (int i = 0; i < NumStages; i++) begin
                pipe_tag_q[i] <= '0;
                pipe_res_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_zero_q[0]  <= exp_zero;
            pipe_tag_q[0]   <= cmd_tag;
            pipe_res_q[0]   <= exp_result;
            for (int i = 1; i < NumStages; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_zero_q[i]  <= pipe_zero_q[i-1];
                pipe_tag_q[i]   <= pipe_tag_q[i-1];
                pipe_res_q[i]   <= pipe_res_q[i-1];
            end
        end
    end

    logic cap_mismatch;

    assign capture      = pipe_valid_q[Last];
    assign cap_mismatch = (alu_result != pipe_res_q[Last]) || (alu_zero != pipe_zero_q[Last]);

    logic [3:0]           fifo_res_q [RSP_DEPTH];
    logic [TAG_W-1:0]     fifo_tag_q [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_zero_q;
    logic [RSP_DEPTH-1:0] fifo_mis_q;
    logic [PtrW-1:0]      wptr_q;
    logic [PtrW-1:0]      rptr_q;
    logic [CntW-1:0]      count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_zero_q <= '0;
            fifo_mis_q  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_res_q[i] <= '0;
                fifo_tag_q[i] <= '0;
            end
        end else if (capture) begin
            fifo_res_q[wptr_q]  <= alu_result;
            fifo_zero_q[wptr_q] <= alu_zero;
            fifo_tag_q[wptr_q]  <= pipe_tag_q[Last];
            fifo_mis_q[wptr_q]  <= cap_mismatch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (capture) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (capture && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !capture) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Last popped entry, so the outputs hold steady while the FIFO is empty.
    logic [3:0]       last_res_q;
    logic [TAG_W-1:0] last_tag_q;
    logic             last_zero_q;
    logic             last_mis_q;

    assign rsp_valid = (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_res_q  <= '0;
            last_tag_q  <= '0;
            last_zero_q <= 1'b0;
            last_mis_q  <= 1'b0;
        end else if (pop) begin
            last_res_q  <= fifo_res_q[rptr_q];
            last_tag_q  <= fifo_tag_q[rptr_q];
            last_zero_q <= fifo_zero_q[rptr_q];
            last_mis_q  <= fifo_mis_q[rptr_q];
        end
    end

    always_comb begin
        if (rsp_valid) begin
            rsp_result   = fifo_res_q[rptr_q];
            rsp_zero     = fifo_zero_q[rptr_q];
            rsp_tag      = fifo_tag_q[rptr_q];
            rsp_mismatch = fifo_mis_q[rptr_q];
        end else begin
            rsp_result   = last_res_q;
            rsp_zero     = last_zero_q;
            rsp_tag      = last_tag_q;
            rsp_mismatch = last_mis_q;
        end
    end

endmodule

// File: tb/tb_alu_4bit_issuer.sv
// Bench for alu_4bit_issuer: behavioural two-register ALU with fault injection, directed cases
// and a randomized run checked against a queue-based response model.
module tb_alu_4bit_issuer;

    localparam int unsigned RSP_DEPTH = 4;
    localparam int unsigned TAG_W     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic [1:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [1:0]       alu_sel;
    logic [3:0]       alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_result;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_mismatch;

    logic fault_plus1;
    logic force_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_count = 0;

    typedef struct packed {
        logic [3:0]       res;
        logic             zero;
        logic [TAG_W-1:0] tag;
        logic             mis;
    } rsp_t;

    rsp_t model_q[$];

    always #5 clk = ~clk;

    alu_4bit_issuer #(
        .ALU_LAT   (2),
        .RSP_DEPTH (RSP_DEPTH),
        .TAG_W     (TAG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .cmd_tag      (cmd_tag),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_tag      (rsp_tag),
        .rsp_mismatch (rsp_mismatch)
    );

    function automatic logic [3:0] ref_alu(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return 4'(((r % 16) + 16) % 16);
    endfunction

    // The ALU itself: input register then output register, with optional faults.
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_sel;

    always @(posedge clk) begin
        logic [3:0] r;
        in_a   <= alu_a;
        in_b   <= alu_b;
        in_sel <= alu_sel;
        r = ref_alu(int'(in_a), int'(in_b), int'(in_sel));
        if (fault_plus1 && in_sel == 2'b00) r = r + 4'd1;
        alu_result <= r;
        alu_zero   <= force_zero ? 1'b1 : (r == 4'd0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response model: one entry per accepted command, retired in order on each pop.
    always @(negedge clk) begin
        rsp_t e;
        logic [3:0] good;
        if (rst) begin
            model_q.delete();
            check_eq("ready_in_reset", 32'(cmd_ready), 32'd0);
        end else begin
            check_eq("cmd_ready_credit", 32'(cmd_ready), 32'(model_q.size() < RSP_DEPTH));
            if (rsp_valid && rsp_ready) begin
                if (model_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = model_q.pop_front();
                    check_eq("rsp_result", 32'(rsp_result), 32'(e.res));
                    check_eq("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                    check_eq("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                    check_eq("rsp_mismatch", 32'(rsp_mismatch), 32'(e.mis));
                end
            end
            if (cmd_valid && cmd_ready) begin
                good  = ref_alu(int'(cmd_a), int'(cmd_b), int'(cmd_op));
                e.res = (fault_plus1 && cmd_op == 2'b00) ? good + 4'd1 : good;
                e.zero = force_zero ? 1'b1 : (e.res == 4'd0);
                e.tag = cmd_tag;
                e.mis = (e.res != good) || (e.zero != (good == 4'd0));
                model_q.push_back(e);
                acc_count++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input int a, input int b, input int op, input int tag);
        cmd_valid = 1'b1;
        cmd_a     = 4'(a);
        cmd_b     = 4'(b);
        cmd_op    = 2'(op);
        cmd_tag   = TAG_W'(tag);
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        check_eq(tag, 32'(rsp_valid), 32'd1);
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) tick();
        rsp_ready = 1'b0;
        check_eq("drained", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int acc0;
        int last_acc;
        int cyc;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        cmd_tag = '0;
        rsp_ready = 1'b0;
        fault_plus1 = 1'b0;
        force_zero = 1'b0;

        repeat (3) tick();
        check_eq("rst_alu_a", 32'(alu_a), 32'd0);
        check_eq("rst_alu_b", 32'(alu_b), 32'd0);
        check_eq("rst_alu_sel", 32'(alu_sel), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_result", 32'(rsp_result), 32'd0);
        check_eq("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check_eq("rst_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Single add: 9 + 8 = 17 -> 1, three-edge latency.
        drive_cmd(9, 8, 0, 3);
        tick();
        cmd_valid = 1'b0;
        check_eq("issue_alu_a", 32'(alu_a), 32'd9);
        check_eq("issue_alu_b", 32'(alu_b), 32'd8);
        check_eq("issue_alu_sel", 32'(alu_sel), 32'd0);
        check_eq("lat_e0", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("lat_e1", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("lat_e2", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("lat_e3", 32'(rsp_valid), 32'd1);
        check_eq("add_result", 32'(rsp_result), 32'd1);
        check_eq("add_zero", 32'(rsp_zero), 32'd0);
        check_eq("add_tag", 32'(rsp_tag), 32'd3);
        check_eq("add_mismatch", 32'(rsp_mismatch), 32'd0);
        pop_one();
        check_eq("empty_after_pop", 32'(rsp_valid), 32'd0);
        check_eq("hold_last_result", 32'(rsp_result), 32'd1);

        // Back-to-back zero results, consumed on consecutive cycles.
        rsp_ready = 1'b1;
        drive_cmd(5, 5, 1, 1);
        tick();
        drive_cmd(15, 0, 2, 2);
        tick();
        drive_cmd(0, 0, 3, 3);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            check_eq("b2b_valid", 32'(rsp_valid), 32'd1);
            check_eq("b2b_tag", 32'(rsp_tag), 32'(i));
            check_eq("b2b_result", 32'(rsp_result), 32'd0);
            check_eq("b2b_zero", 32'(rsp_zero), 32'd1);
            tick();
        end
        check_eq("b2b_empty", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Credit exhaustion and recovery.
        acc0 = acc_count;
        for (int i = 0; i < 8; i++) begin
            drive_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), i);
            tick();
        end
        check_eq("credit_accepts", 32'(acc_count - acc0), 32'd4);
        check_eq("credit_stall", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        #1;
        check_eq("no_comb_credit", 32'(cmd_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        check_eq("credit_freed", 32'(cmd_ready), 32'd1);
        tick();
        check_eq("fifth_accept", 32'(acc_count - acc0), 32'd5);
        check_eq("credit_stall2", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        pop_one();
        check_eq("credit_one", 32'(cmd_ready), 32'd1);
        drive_cmd(1, 2, 3, 7);
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check_eq("acc_pop_same", 32'(cmd_ready), 32'd1);
        drive_cmd(2, 2, 2, 8);
        tick();
        cmd_valid = 1'b0;
        check_eq("credit_was_one", 32'(cmd_ready), 32'd0);
        drain();

        // Faulty ALU: add off by one, then forced zero flag.
        fault_plus1 = 1'b1;
        drive_cmd(3, 4, 0, 5);
        tick();
        cmd_valid = 1'b0;
        wait_rsp("fault_add_timeout");
        check_eq("fault_add_result", 32'(rsp_result), 32'd8);
        check_eq("fault_add_mismatch", 32'(rsp_mismatch), 32'd1);
        pop_one();
        fault_plus1 = 1'b0;
        force_zero = 1'b1;
        drive_cmd(3, 3, 0, 6);
        tick();
        cmd_valid = 1'b0;
        wait_rsp("fault_zero_timeout");
        check_eq("fault_zero_result", 32'(rsp_result), 32'd6);
        check_eq("fault_zero_flag", 32'(rsp_zero), 32'd1);
        check_eq("fault_zero_mismatch", 32'(rsp_mismatch), 32'd1);
        pop_one();
        force_zero = 1'b0;

        // Reset with two commands in flight.
        drive_cmd(7, 2, 0, 9);
        tick();
        drive_cmd(12, 3, 1, 10);
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_alu_a", 32'(alu_a), 32'd0);
        check_eq("midrst_alu_b", 32'(alu_b), 32'd0);
        check_eq("midrst_alu_sel", 32'(alu_sel), 32'd0);
        check_eq("midrst_ready", 32'(cmd_ready), 32'd0);
        check_eq("midrst_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("postrst_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("postrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        acc0 = acc_count;
        for (int i = 0; i < 6; i++) begin
            drive_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), i);
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("postrst_credit", 32'(acc_count - acc0), 32'd4);
        drain();

        // Randomized traffic.
        acc0 = acc_count;
        last_acc = acc_count;
        cyc = 0;
        cmd_valid = 1'b0;
        while ((acc_count - acc0) < 1000 && cyc < 20000) begin
            if (!cmd_valid || acc_count != last_acc) begin
                drive_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
                cmd_valid = ($urandom_range(0, 3) != 0);
            end
            last_acc = acc_count;
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        check_eq("random_accepts", 32'(acc_count - acc0), 32'd1000);
        drain();
        check_eq("model_empty", 32'(model_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
